mips_cpu_muldiv_seq: RTL and testbench

MIPS_CPU_MULDIV_SEQ -- requirements
Module: mips_cpu_muldiv_seq

---
 rtl/mips_cpu_muldiv_seq.sv | 154 +++++++++++++++
 tb/tb_mips_cpu_muldiv_seq.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_muldiv_seq.sv
// Sequential MIPS HI/LO unit: radix-2 shift-add multiply and restoring divide,
// with MTHI/MTLO writes, abort (pipeline flush) and divide-by-zero short cut.
module mips_cpu_muldiv_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [2:0] OpMult  = 3'b001;
    localparam logic [2:0] OpMultu = 3'b010;
    localparam logic [2:0] OpDiv   = 3'b011;
    localparam logic [2:0] OpDivu  = 3'b100;
    localparam logic [2:0] OpMthi  = 3'b101;
    localparam logic [2:0] OpMtlo  = 3'b110;
    localparam int unsigned W2 = 2 * WIDTH;

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W2-1:0]    acc_q;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             div_q;
    logic             qneg_q;
    logic             rneg_q;
    logic             done_q;

    logic             is_div;
    logic             is_muldiv;
    logic             is_signed;
    logic [WIDTH-1:0] a_op;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_top;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [W2-1:0]    step_acc;
    logic [W2-1:0]    fix_acc;

    assign acc_hi = acc_q[W2-1:WIDTH];
    assign acc_lo = acc_q[WIDTH-1:0];

    always_comb begin
        is_div    = (op == OpDiv) || (op == OpDivu);
        is_muldiv = is_div || (op == OpMult) || (op == OpMultu);
        is_signed = (op == OpMult) || (op == OpDiv);
        a_op      = (is_signed && a[WIDTH-1]) ? -a : a;
        b_op      = (is_signed && b[WIDTH-1]) ? -b : b;
    end

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum  = {1'b0, acc_hi} + {1'b0, {WIDTH{acc_q[0]}} & opnd_q};
        div_top  = acc_q[W2-1:WIDTH-1];
        div_ge   = div_top >= {1'b0, opnd_q};
        div_diff = div_top[WIDTH-1:0] - opnd_q;
        if (div_q) begin
            step_acc = {(div_ge ? div_diff : div_top[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
            fix_acc  = {(rneg_q ? -acc_hi : acc_hi), (qneg_q ? -acc_lo : acc_lo)};
        end else begin
            step_acc = {mul_sum, acc_q[WIDTH-1:1]};
            fix_acc  = qneg_q ? -acc_q : acc_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            div_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start && !abort) begin
                        if (is_muldiv) begin
                            div_q  <= is_div;
                            qneg_q <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                            rneg_q <= is_signed && a[WIDTH-1];
                            if (is_div && (b == '0)) begin
                                // Divide by zero: result is preloaded, go straight to commit
                                acc_q   <= {a, {WIDTH{1'b1}}};
                                state_q <= StDone;
                            end else begin
                                acc_q   <= {{WIDTH{1'b0}}, a_op};
                                opnd_q  <= b_op;
                                cnt_q   <= CNT_W'(WIDTH);
                                state_q <= StRun;
                            end
                        end else if (op == OpMthi) begin
                            hi_q <= a;
                        end else if (op == OpMtlo) begin
                            lo_q <= a;
                        end
                    end
                end
                StRun: begin
                    if (abort) begin
                        state_q <= StIdle;
                    end else begin
                        acc_q <= step_acc;
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= StFix;
                        end
                    end
                end
                StFix: begin
                    if (abort) begin
                        state_q <= StIdle;
                    end else begin
                        acc_q   <= fix_acc;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    // Already committed: abort is ignored here
                    hi_q    <= acc_hi;
                    lo_q    <= acc_lo;
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv_seq.sv
// Randomized self-checking bench for mips_cpu_muldiv_seq against an arithmetic
// reference model of HI/LO results and handshake timing.
module tb_mips_cpu_muldiv_seq;
    localparam int W = 32;
    localparam logic [2:0] OpMult  = 3'b001;
    localparam logic [2:0] OpMultu = 3'b010;
    localparam logic [2:0] OpDiv   = 3'b011;
    localparam logic [2:0] OpDivu  = 3'b100;
    localparam logic [2:0] OpMthi  = 3'b101;
    localparam logic [2:0] OpMtlo  = 3'b110;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         abort;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int           n_checks = 0;
    int           n_err = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    mips_cpu_muldiv_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected HI/LO and cycles from accept edge to the done pulse.
    function automatic void model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] eh, output logic [W-1:0] el,
                                  output int lat);
        logic [63:0] p;
        longint      sx;
        longint      sy;
        lat = W + 2;
        eh  = '0;
        el  = '0;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        if (o == OpMult) begin
            p = sx * sy;
            eh = p[63:32];
            el = p[31:0];
        end else if (o == OpMultu) begin
            p = {32'b0, x} * {32'b0, y};
            eh = p[63:32];
            el = p[31:0];
        end else if (y == '0) begin
            eh = x;
            el = '1;
            lat = 1;
        end else if (o == OpDiv) begin
            p = sx / sy;
            el = p[31:0];
            p = sx % sy;
            eh = p[31:0];
        end else begin
            el = x / y;
            eh = x % y;
        end
    endfunction

    function automatic logic [W-1:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'h8000_0000;
            2: return '1;
            3: return W'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue at a negedge; returns at the negedge sample where done is seen.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit junk);
        logic [W-1:0] eh;
        logic [W-1:0] el;
        int lat;
        int s;
        int nbusy;
        bit hold_ok;
        model(o, x, y, eh, el, lat);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check_eq("done_low_after_accept", done, 0);
        s = 0;
        nbusy = 0;
        hold_ok = 1'b1;
        while (!done && s < 100) begin
            if (busy) nbusy++;
            if (hi !== m_hi || lo !== m_lo) hold_ok = 1'b0;
            if (junk) begin
                start = 1'b1;
                op = 3'($urandom_range(0, 7));
                a = $urandom;
                b = $urandom;
            end
            @(negedge clk);
            s++;
        end
        start = 1'b0;
        check_eq("latency", s, lat);
        check_eq("busy_cycles", nbusy, lat);
        check_eq("hilo_hold_while_busy", hold_ok, 1);
        check_eq("busy_at_done", busy, 0);
        check_eq("hi", hi, eh);
        check_eq("lo", lo, el);
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic run_mt(input logic [2:0] o, input logic [W-1:0] x);
        start = 1'b1;
        op = o;
        a = x;
        b = $urandom;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        if (o == OpMthi) m_hi = x;
        if (o == OpMtlo) m_lo = x;
        check_eq("mt_hi", hi, m_hi);
        check_eq("mt_lo", lo, m_lo);
        check_eq("mt_busy", busy, 0);
        check_eq("mt_done", done, 0);
    endtask

    // Abort is driven during the busy sample number 'at' (0 = first busy cycle).
    task automatic run_abort(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                             input int at_req);
        logic [W-1:0] eh;
        logic [W-1:0] el;
        int lat;
        int at;
        int nd;
        bit wrote;
        model(o, x, y, eh, el, lat);
        at = (at_req > lat - 1) ? lat - 1 : at_req;
        wrote = (at == lat - 1);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (at) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        if (wrote) begin
            m_hi = eh;
            m_lo = el;
        end
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, wrote);
        check_eq("abort_hi", hi, m_hi);
        check_eq("abort_lo", lo, m_lo);
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) nd++;
        end
        check_eq("abort_no_late_done", nd, 0);
    endtask

    initial begin
        logic [2:0]   o;
        logic [W-1:0] x;
        logic [W-1:0] y;
        int           nd;
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        #1;
        check_eq("rst_hi", hi, 0);
        check_eq("rst_lo", lo, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        @(negedge clk);
        reset = 1'b1;

        run_op(OpMult, 32'hFFFF_FFFD, 32'd5, 1'b0);
        check_eq("mult_neg3x5_hi", hi, 32'hFFFF_FFFF);
        check_eq("mult_neg3x5_lo", lo, 32'hFFFF_FFF1);
        run_op(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check_eq("multu_max_hi", hi, 32'hFFFF_FFFE);
        check_eq("multu_max_lo", lo, 32'h0000_0001);
        run_op(OpDiv, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check_eq("div_neg7_lo", lo, 32'hFFFF_FFFD);
        check_eq("div_neg7_hi", hi, 32'hFFFF_FFFF);
        run_op(OpDivu, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check_eq("divu_lo", lo, 32'h7FFF_FFFC);
        check_eq("divu_hi", hi, 32'h0000_0001);
        run_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check_eq("div_ovf_lo", lo, 32'h8000_0000);
        check_eq("div_ovf_hi", hi, 32'h0);
        run_op(OpDivu, 32'd9, 32'd0, 1'b0);
        check_eq("div0_lo", lo, 32'hFFFF_FFFF);
        check_eq("div0_hi", hi, 32'd9);

        run_mt(OpMthi, 32'h0000_1234);
        check_eq("mthi_val", hi, 32'h0000_1234);
        run_abort(OpMult, 32'd77, 32'd99, 9);
        check_eq("abort_keeps_mthi", hi, 32'h0000_1234);
        run_abort(OpMultu, $urandom, $urandom, W + 1);

        // abort with start in IDLE drops the request
        start = 1'b1;
        abort = 1'b1;
        op = OpMthi;
        a = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check_eq("abort_start_hi", hi, m_hi);
        check_eq("abort_start_busy", busy, 0);

        // start held during busy must be ignored
        run_op(OpMult, 32'h0001_2345, 32'h0000_0777, 1'b1);
        run_op(OpDiv, 32'h8765_4321, 32'h0000_0123, 1'b1);

        // reset mid-operation
        start = 1'b1;
        op = OpMult;
        a = 32'h1111_1111;
        b = 32'h2222_2222;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        m_hi = '0;
        m_lo = '0;
        check_eq("midrst_hi", hi, 0);
        check_eq("midrst_lo", lo, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_done", done, 0);
        @(negedge clk);
        reset = 1'b1;
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        check_eq("midrst_quiet", nd, 0);

        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            x = rnd_opnd();
            y = rnd_opnd();
            if (o inside {OpMult, OpMultu, OpDiv, OpDivu}) begin
                if ($urandom_range(0, 6) == 0) run_abort(o, x, y, $urandom_range(0, W + 1));
                else run_op(o, x, y, $urandom_range(0, 3) == 0);
            end else begin
                run_mt(o, x);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
